// File: rtl/cell_alloc_ctrl_pkg.sv
// Shared types and constants for the ESFA cell allocation path.
package esfa_pkg;
  localparam int HANDLE_W = 8;
  localparam int CODE_W   = 8;
  localparam logic [HANDLE_W-1:0] NULL_HANDLE = 8'hFF;

  typedef enum logic [1:0] {IDLE, SCAN, CLAIM, RESP} alloc_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cell_alloc_ctrl_if.sv
// Sequencer request/response, cell array flags and claim strobe bundled together.
interface cell_alloc_ctrl_if #(parameter int NUM_CELLS = 16);
  import esfa_pkg::*;

  logic                                req_valid;
  logic                                req_ready;
  logic [CODE_W-1:0]                   req_array_code;
  logic [NUM_CELLS-1:0]                cell_free;
  logic [NUM_CELLS-1:0][HANDLE_W-1:0]  cell_handle;
  logic                                claim_valid;
  logic [HANDLE_W-1:0]                 claim_handle;
  logic [CODE_W-1:0]                   claim_array_code;
  logic                                resp_valid;
  logic                                resp_ready;
  logic                                resp_ok;
  logic [HANDLE_W-1:0]                 resp_handle;

  // Allocator side
  modport slave (
    input  req_valid, req_array_code, cell_free, cell_handle, resp_ready,
    output req_ready, claim_valid, claim_handle, claim_array_code,
           resp_valid, resp_ok, resp_handle
  );

  // Sequencer / cell array side
  modport master (
    output req_valid, req_array_code, cell_free, cell_handle, resp_ready,
    input  req_ready, claim_valid, claim_handle, claim_array_code,
           resp_valid, resp_ok, resp_handle
  );
endinterface

// File: rtl/cell_alloc_ctrl_free_cell_prio_enc.sv
// Lowest-index-wins priority encoder over one chunk of free flags.
module free_cell_prio_enc
  import esfa_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = idx_w(W)
) (
  input  logic [W-1:0]  i_bits,
  output logic          o_hit,
  output logic [IW-1:0] o_idx
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_bits[i]) o_idx = IW'(i);
    end
    o_hit = |i_bits;
  end

endmodule

// File: rtl/cell_alloc_ctrl.sv
// Allocation initiator: scans free flags a chunk per cycle, claims the
// lowest-index free cell and returns its handle to the sequencer.
module cell_alloc_ctrl
  import esfa_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int CHUNK     = 4
) (
  input  logic             clk,
  input  logic             rst,
  cell_alloc_ctrl_if.slave bus
);

  localparam int NCHUNK = NUM_CELLS / CHUNK;
  localparam int CIDX_W = idx_w(NCHUNK);
  localparam int JIDX_W = idx_w(CHUNK);

  alloc_state_t        r_state, w_next;
  logic [CIDX_W-1:0]   r_chunk_idx;
  logic [CODE_W-1:0]   r_code;
  logic [HANDLE_W-1:0] r_handle;
  logic                r_resp_ok;
  logic [HANDLE_W-1:0] r_resp_handle;

  // Flags and handles viewed as [chunk][cell-in-chunk] so the live chunk is a plain index.
  logic [NCHUNK-1:0][CHUNK-1:0]               w_free_2d;
  logic [NCHUNK-1:0][CHUNK-1:0][HANDLE_W-1:0] w_hdl_3d;
  logic [CHUNK-1:0]                           w_chunk_bits;
  logic                                       w_hit;
  logic [JIDX_W-1:0]                          w_j;
  logic                                       w_last;

  assign w_free_2d    = bus.cell_free;
  assign w_hdl_3d     = bus.cell_handle;
  // Flags are sampled live each SCAN cycle; earlier chunks are never revisited.
  assign w_chunk_bits = w_free_2d[r_chunk_idx];
  assign w_last       = (r_chunk_idx == CIDX_W'(NCHUNK - 1));

  free_cell_prio_enc #(.W(CHUNK), .IW(JIDX_W)) u_enc (
    .i_bits (w_chunk_bits),
    .o_hit  (w_hit),
    .o_idx  (w_j)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    w_next          = r_state;
    bus.req_ready   = 1'b0;
    bus.claim_valid = 1'b0;
    bus.resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = SCAN;
      end
      SCAN: begin
        if (w_hit)       w_next = CLAIM;
        else if (w_last) w_next = RESP;
      end
      CLAIM: begin
        bus.claim_valid = 1'b1;
        w_next          = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath latches: request code, scan position, found handle and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunk_idx   <= '0;
      r_code        <= '0;
      r_handle      <= '0;
      r_resp_ok     <= 1'b0;
      r_resp_handle <= NULL_HANDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_code      <= bus.req_array_code;
            r_chunk_idx <= '0;
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_handle <= w_hdl_3d[r_chunk_idx][w_j];
          end else if (w_last) begin
            r_resp_ok     <= 1'b0;
            r_resp_handle <= NULL_HANDLE;
          end else begin
            r_chunk_idx <= r_chunk_idx + CIDX_W'(1);
          end
        end
        CLAIM: begin
          r_resp_ok     <= 1'b1;
          r_resp_handle <= r_handle;
        end
        default: ;
      endcase
    end
  end

  assign bus.claim_handle     = r_handle;
  assign bus.claim_array_code = r_code;
  assign bus.resp_ok          = r_resp_ok;
  assign bus.resp_handle      = r_resp_handle;

endmodule

// File: tb/tb_cell_alloc_ctrl.sv
// Scoreboard bench: requests push expected claim/response records, a negedge
// monitor pops and compares them whenever the DUT strobes an output.
module tb_cell_alloc_ctrl;
  import esfa_pkg::*;

  localparam int NUM_CELLS = 16;
  localparam int CHUNK     = 4;
  localparam int NCH       = NUM_CELLS / CHUNK;

  typedef struct { logic [7:0] h; logic [7:0] c; int cyc; } claim_t;
  typedef struct { logic ok; logic [7:0] h; int cyc; } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cell_alloc_ctrl_if #(.NUM_CELLS(NUM_CELLS)) bus ();

  cell_alloc_ctrl #(.NUM_CELLS(NUM_CELLS), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  claim_t q_claim[$];
  resp_t  q_resp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   bus.req_ready, 1);
    chk({tag, "_claim_valid"}, bus.claim_valid, 0);
    chk({tag, "_claim_handle"}, bus.claim_handle, 0);
    chk({tag, "_claim_code"},  bus.claim_array_code, 0);
    chk({tag, "_resp_valid"},  bus.resp_valid, 0);
    chk({tag, "_resp_ok"},     bus.resp_ok, 0);
    chk({tag, "_resp_handle"}, bus.resp_handle, 8'hFF);
  endtask

  // Waits for IDLE, presents one request and records the expected outcome.
  // Returns #1 after the accepting edge (first SCAN cycle); acc is the accept cycle.
  task automatic do_req(input logic [7:0] code, input logic [15:0] free,
                        input bit hit, input logic [7:0] eh, input int k,
                        input bit push, input int hb, output int acc);
    bit got = 0;
    claim_t ce;
    resp_t  re;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
    end
    chk("req_accept", int'(got), 1);
    for (int i = 0; i < NUM_CELLS; i++) bus.cell_handle[i] = 8'(hb + i);
    bus.cell_free      = free;
    bus.req_array_code = code;
    bus.req_valid      = 1'b1;
    acc = cyc;
    if (push) begin
      if (hit) begin
        ce.h = eh; ce.c = code; ce.cyc = acc + 2 + k;
        q_claim.push_back(ce);
      end
      re.ok  = hit;
      re.h   = hit ? eh : 8'hFF;
      re.cyc = hit ? acc + 3 + k : acc + NCH + 1;
      q_resp.push_back(re);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Monitor: compares every claim pulse and response handshake against the queues.
  logic   prev_rv = 1'b0;
  int     rise    = 0;
  claim_t m_ce;
  resp_t  m_re;
  always @(negedge clk) begin
    if (bus.claim_valid) begin
      chk("claim_expected", int'(q_claim.size() != 0), 1);
      if (q_claim.size() != 0) begin
        m_ce = q_claim.pop_front();
        chk("claim_handle", bus.claim_handle, m_ce.h);
        chk("claim_code",   bus.claim_array_code, m_ce.c);
        chk("claim_cycle",  cyc, m_ce.cyc);
      end
    end
    if (bus.resp_valid && !prev_rv) rise = cyc;
    prev_rv = bus.resp_valid;
    if (bus.resp_valid && bus.resp_ready) begin
      chk("resp_expected", int'(q_resp.size() != 0), 1);
      if (q_resp.size() != 0) begin
        m_re = q_resp.pop_front();
        chk("resp_ok",     bus.resp_ok, m_re.ok);
        chk("resp_handle", bus.resp_handle, m_re.h);
        chk("resp_cycle",  rise, m_re.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc2, h;
    bit got;
    bus.req_valid      = 1'b0;
    bus.req_array_code = '0;
    bus.cell_free      = '0;
    bus.resp_ready     = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) bus.cell_handle[i] = 8'(i);

    // Reset values
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst0");
    rst = 1'b0;

    // Chunk-0 hit: claim at +2, response at +3
    do_req(8'h05, 16'h0001, 1, 8'h00, 0, 1, 0, acc);
    // Chunk-2 hit, lowest of two set bits
    do_req(8'h3C, 16'h0300, 1, 8'h08, 2, 1, 0, acc);
    // Full array: no claim, NULL handle at +5
    do_req(8'h77, 16'h0000, 0, 8'hFF, 0, 1, 0, acc);
    // All free: lowest index wins
    do_req(8'h5A, 16'hFFFF, 1, 8'h00, 0, 1, 0, acc);
    // Only the last cell free, non-identity handles
    do_req(8'hC3, 16'h8000, 1, 8'hAF, 3, 1, 8'hA0, acc);

    // Back-pressure: response held stable, new request waits
    do_req(8'h11, 16'h0040, 1, 8'h06, 1, 1, 0, acc);
    bus.resp_ready = 1'b0;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1;
    end
    chk("hold_resp_rise", int'(got), 1);
    bus.req_valid      = 1'b1;
    bus.req_array_code = 8'h22;
    for (int i = 0; i < 10; i++) begin
      chk("hold_resp_valid", bus.resp_valid, 1);
      chk("hold_resp_ok",    bus.resp_ok, 1);
      chk("hold_resp_handle", bus.resp_handle, 8'h06);
      chk("hold_req_ready",  bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    h = cyc;
    do_req(8'h22, 16'h0010, 1, 8'h04, 1, 1, 0, acc2);
    chk("reaccept_cycle", acc2, h + 1);

    // Late-freed cells: bit 1 in a scanned chunk ignored, bit 12 found in chunk 3
    do_req(8'h33, 16'h0000, 1, 8'h0C, 3, 1, 0, acc);
    @(posedge clk); #1 bus.cell_free[1]  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.cell_free[12] = 1'b1;

    // Reset during CLAIM: pulse dropped, outputs at reset values, no response
    do_req(8'h44, 16'h0001, 1, 8'h00, 0, 0, 0, acc);
    @(posedge clk);
    #1 chk("pre_rst_claim_valid", bus.claim_valid, 1);
    rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", bus.resp_valid, 0);
    end

    chk("claim_queue_empty", q_claim.size(), 0);
    chk("resp_queue_empty",  q_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
